// File: rtl/ssram_tcm_if.sv
// Request/response bus between the core and the tightly coupled SRAM.
// Signal suffixes describe direction as seen from the memory (slave) side.
interface ssram_tcm_if #(
  parameter int C_ADDR_SZ = 32
) ();
  logic                 treqready_o;
  logic                 treqvalid_i;
  logic                 treqdvalid_i;
  logic [1:0]           treqsize_i;
  logic [C_ADDR_SZ-1:0] treqaddr_i;
  logic [31:0]          treqdata_i;
  logic                 trspready_i;
  logic                 trspvalid_o;
  logic                 trsprerr_o;
  logic                 trspwerr_o;
  logic [31:0]          trspdata_o;

  modport master (
    input  treqready_o,
    output treqvalid_i, treqdvalid_i, treqsize_i, treqaddr_i, treqdata_i,
    output trspready_i,
    input  trspvalid_o, trsprerr_o, trspwerr_o, trspdata_o
  );

  modport slave (
    output treqready_o,
    input  treqvalid_i, treqdvalid_i, treqsize_i, treqaddr_i, treqdata_i,
    input  trspready_i,
    output trspvalid_o, trsprerr_o, trspwerr_o, trspdata_o
  );
endinterface

// File: rtl/ssram_tcm.sv
// Single-port data SRAM with sized/lane-enabled accesses, error responses,
// a fixed-latency read pipeline and a credit-protected in-order response FIFO.
module ssram_tcm #(
  parameter int C_ADDR_SZ        = 32,
  parameter int C_DEPTH_LOG2     = 12,
  parameter int C_LATENCY        = 1,
  parameter int C_RSP_FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       resetb_i,
  input  logic       clk_en_i,
  ssram_tcm_if.slave bus
);

  localparam int WORDS = 1 << C_DEPTH_LOG2;
  localparam int CW    = $clog2(C_RSP_FIFO_DEPTH + 1);
  localparam int PW    = $clog2(C_RSP_FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(C_RSP_FIFO_DEPTH);

  typedef struct packed {
    logic        rerr;
    logic        werr;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]          mem_q [WORDS];
  rsp_t                 pipe_q [C_LATENCY];
  rsp_t                 pipe_d [C_LATENCY];
  logic [C_LATENCY-1:0] pv_q, pv_d;
  rsp_t                 fifo_q [C_RSP_FIFO_DEPTH];
  rsp_t                 fifo_d [C_RSP_FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [C_ADDR_SZ-1:0]    addr;
  logic [C_DEPTH_LOG2-1:0] idx;
  logic [1:0]              lane;
  logic [3:0]              be;
  logic                    misalign, out_of_range, req_err;
  logic                    accept, pop, push, fifo_empty, mem_we;
  rsp_t                    new_rsp, head;

  assign addr = bus.treqaddr_i;
  assign idx  = addr[C_DEPTH_LOG2+1:2];
  assign lane = addr[1:0];

  // Ready depends only on the credit counter, never on this cycle's inputs.
  assign bus.treqready_o = (cnt_q < CNT_MAX);
  assign accept     = bus.treqvalid_i & bus.treqready_o & clk_en_i & resetb_i;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign pop        = ~fifo_empty & bus.trspready_i & clk_en_i;
  assign push       = pv_q[C_LATENCY-1] & clk_en_i;
  assign head       = fifo_q[rd_ptr_q[PW-2:0]];

  assign bus.trspvalid_o = ~fifo_empty;
  assign bus.trspdata_o  = fifo_empty ? 32'd0 : head.data;
  assign bus.trsprerr_o  = ~fifo_empty & head.rerr;
  assign bus.trspwerr_o  = ~fifo_empty & head.werr;

  always_comb begin
    misalign = 1'b0;
    be       = 4'b0000;
    case (bus.treqsize_i)
      2'd0: be = 4'b0001 << lane;
      2'd1: begin
        misalign = lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        misalign = (lane != 2'b00);
        be       = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
    out_of_range = ((addr >> (C_DEPTH_LOG2 + 2)) != '0);
    req_err      = misalign | out_of_range;
    mem_we       = accept & bus.treqdvalid_i & ~req_err;
    new_rsp.rerr = req_err & ~bus.treqdvalid_i;
    new_rsp.werr = req_err & bus.treqdvalid_i;
    new_rsp.data = (req_err | bus.treqdvalid_i) ? 32'd0 : mem_q[idx];
  end

  // Pipeline never stalls: credits reserve a FIFO slot for every accepted request.
  always_comb begin
    pv_d     = pv_q;
    pipe_d   = pipe_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clk_en_i) begin
      pv_d[0]   = accept;
      pipe_d[0] = new_rsp;
      for (int i = 1; i < C_LATENCY; i++) begin
        pv_d[i]   = pv_q[i-1];
        pipe_d[i] = pipe_q[i-1];
      end
    end
    if (push) begin
      fifo_d[wr_ptr_q[PW-2:0]] = pipe_q[C_LATENCY-1];
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      pv_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pv_q     <= pv_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage carries no reset; it is only observed behind valid flags.
  always_ff @(posedge clk_i) begin
    pipe_q <= pipe_d;
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= bus.treqdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ssram_tcm.sv
// Directed bench for ssram_tcm: instance a has latency 1, instance b latency 3
// with a 16-word memory; both share clock and reset.
module tb_ssram_tcm;

  logic clk;
  logic resetb;
  logic clk_en_a;
  logic clk_en_b;
  int   check_count;
  int   pass_count;
  int   w;
  int   n_acc;
  logic [31:0] exp_a [4];
  logic [31:0] exp_b [3];

  ssram_tcm_if #(.C_ADDR_SZ(32)) a ();
  ssram_tcm_if #(.C_ADDR_SZ(32)) b ();

  ssram_tcm #(
    .C_ADDR_SZ(32), .C_DEPTH_LOG2(12), .C_LATENCY(1), .C_RSP_FIFO_DEPTH(4)
  ) dut_a (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en_a), .bus(a)
  );

  ssram_tcm #(
    .C_ADDR_SZ(32), .C_DEPTH_LOG2(4), .C_LATENCY(3), .C_RSP_FIFO_DEPTH(4)
  ) dut_b (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en_b), .bus(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One request presented for exactly one edge; caller guarantees ready.
  task automatic applyStimulus(input bit which, input logic wr, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] data);
    if (which) begin
      b.treqvalid_i = 1'b1; b.treqdvalid_i = wr; b.treqsize_i = size;
      b.treqaddr_i = addr;  b.treqdata_i = data;
    end else begin
      a.treqvalid_i = 1'b1; a.treqdvalid_i = wr; a.treqsize_i = size;
      a.treqaddr_i = addr;  a.treqdata_i = data;
    end
    tick();
    a.treqvalid_i = 1'b0;
    b.treqvalid_i = 1'b0;
  endtask

  // Waits (bounded) for a response, checks it, then lets it pop.
  task automatic waitRsp(input bit which, input string tag, input logic rerr, input logic werr,
                         input logic [31:0] data, output int waited);
    waited = 0;
    while (!(which ? b.trspvalid_o : a.trspvalid_o) && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_vld"},  32'(which ? b.trspvalid_o : a.trspvalid_o), 32'd1);
    checkOutput({tag, "_data"}, which ? b.trspdata_o : a.trspdata_o, data);
    checkOutput({tag, "_rerr"}, 32'(which ? b.trsprerr_o : a.trsprerr_o), 32'(rerr));
    checkOutput({tag, "_werr"}, 32'(which ? b.trspwerr_o : a.trspwerr_o), 32'(werr));
    tick();
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    resetb   = 1'b0;
    clk_en_a = 1'b1;
    clk_en_b = 1'b1;
    a.treqvalid_i = 0; a.treqdvalid_i = 0; a.treqsize_i = 0; a.treqaddr_i = 0;
    a.treqdata_i = 0;  a.trspready_i = 1;
    b.treqvalid_i = 0; b.treqdvalid_i = 0; b.treqsize_i = 0; b.treqaddr_i = 0;
    b.treqdata_i = 0;  b.trspready_i = 1;
    @(negedge clk);
    tick();
    checkOutput("rst_rdy",  32'(a.treqready_o), 32'd1);
    checkOutput("rst_vld",  32'(a.trspvalid_o), 32'd0);
    checkOutput("rst_data", a.trspdata_o, 32'd0);
    checkOutput("rst_err",  32'({a.trsprerr_o, a.trspwerr_o}), 32'd0);
    checkOutput("rst_rdy_b", 32'(b.treqready_o), 32'd1);
    resetb = 1'b1;
    tick();

    // Word write then read, latency 1
    applyStimulus(0, 1, 2'd2, 32'h10, 32'hDEADBEEF);
    waitRsp(0, "t1_wr", 0, 0, 32'd0, w);
    checkOutput("t1_wr_lat", 32'(w), 32'd1);
    applyStimulus(0, 0, 2'd2, 32'h10, 32'h0);
    waitRsp(0, "t1_rd", 0, 0, 32'hDEADBEEF, w);
    checkOutput("t1_rd_lat", 32'(w), 32'd1);

    // Lane-enabled sub-word writes
    applyStimulus(0, 1, 2'd2, 32'h10, 32'h11223344); waitRsp(0, "t2_w0", 0, 0, 0, w);
    applyStimulus(0, 1, 2'd0, 32'h13, 32'hAA000000); waitRsp(0, "t2_wb", 0, 0, 0, w);
    applyStimulus(0, 0, 2'd2, 32'h10, 32'h0);        waitRsp(0, "t2_rb", 0, 0, 32'hAA223344, w);
    applyStimulus(0, 1, 2'd1, 32'h12, 32'hBBBB0000); waitRsp(0, "t2_wh", 0, 0, 0, w);
    applyStimulus(0, 0, 2'd2, 32'h10, 32'h0);        waitRsp(0, "t2_rh", 0, 0, 32'hBBBB3344, w);
    applyStimulus(0, 0, 2'd0, 32'h11, 32'h0);        waitRsp(0, "t2_rbyte", 0, 0, 32'hBBBB3344, w);

    // Error responses leave memory untouched
    applyStimulus(0, 1, 2'd2, 32'h00, 32'h01020304); waitRsp(0, "t3_w0", 0, 0, 0, w);
    applyStimulus(0, 1, 2'd2, 32'h04, 32'h55667788); waitRsp(0, "t3_w4", 0, 0, 0, w);
    applyStimulus(0, 1, 2'd2, 32'h08, 32'hCAFEF00D); waitRsp(0, "t3_w8", 0, 0, 0, w);
    applyStimulus(0, 0, 2'd1, 32'h11, 32'h0);        waitRsp(0, "t3_hmis", 1, 0, 0, w);
    applyStimulus(0, 1, 2'd2, 32'h06, 32'hFFFFFFFF); waitRsp(0, "t3_wmis", 0, 1, 0, w);
    applyStimulus(0, 0, 2'd3, 32'h00, 32'h0);        waitRsp(0, "t3_sz3", 1, 0, 0, w);
    applyStimulus(0, 0, 2'd2, 32'h4000, 32'h0);      waitRsp(0, "t3_oor", 1, 0, 0, w);
    applyStimulus(0, 1, 2'd2, 32'h4000, 32'hFFFFFFFF); waitRsp(0, "t3_woor", 0, 1, 0, w);
    applyStimulus(0, 0, 2'd2, 32'h04, 32'h0);        waitRsp(0, "t3_keep4", 0, 0, 32'h55667788, w);
    applyStimulus(0, 0, 2'd2, 32'h00, 32'h0);        waitRsp(0, "t3_keep0", 0, 0, 32'h01020304, w);

    // Backpressure: credits stop acceptance at four outstanding responses
    exp_a[0] = 32'h01020304; exp_a[1] = 32'h55667788;
    exp_a[2] = 32'hCAFEF00D; exp_a[3] = 32'hBBBB3344;
    a.trspready_i = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (a.treqready_o && n_acc < 4) begin
        a.treqvalid_i = 1'b1; a.treqdvalid_i = 1'b0; a.treqsize_i = 2'd2;
        a.treqaddr_i = 32'(n_acc) * 4;
        if (n_acc == 3) a.treqaddr_i = 32'h10;
        tick();
        n_acc++;
      end else begin
        a.treqvalid_i = 1'b1;
        a.treqaddr_i  = 32'h10;
        tick();
      end
    end
    a.treqvalid_i = 1'b0;
    checkOutput("t4_acc", 32'(n_acc), 32'd4);
    checkOutput("t4_full_rdy", 32'(a.treqready_o), 32'd0);
    a.trspready_i = 1'b1;
    checkOutput("t4_rdy_same", 32'(a.treqready_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t4_vld%0d", k), 32'(a.trspvalid_o), 32'd1);
      checkOutput($sformatf("t4_data%0d", k), a.trspdata_o, exp_a[k]);
      tick();
      if (k == 0) checkOutput("t4_rdy_after_pop", 32'(a.treqready_o), 32'd1);
    end
    checkOutput("t4_drained", 32'(a.trspvalid_o), 32'd0);

    // Latency 3 instance: back-to-back reads, then with a 2-cycle clock-enable gap
    exp_b[0] = 32'h10; exp_b[1] = 32'h20; exp_b[2] = 32'h30;
    applyStimulus(1, 1, 2'd2, 32'h0, 32'h10); waitRsp(1, "t5_w0", 0, 0, 0, w);
    checkOutput("t5_wr_lat", 32'(w), 32'd3);
    applyStimulus(1, 1, 2'd2, 32'h4, 32'h20); waitRsp(1, "t5_w1", 0, 0, 0, w);
    applyStimulus(1, 1, 2'd2, 32'h8, 32'h30); waitRsp(1, "t5_w2", 0, 0, 0, w);
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 3; k++) begin
        b.treqvalid_i = 1'b1; b.treqdvalid_i = 1'b0; b.treqsize_i = 2'd2;
        b.treqaddr_i = 32'(k) * 4;
        tick();
      end
      b.treqvalid_i = 1'b0;
      checkOutput($sformatf("t5_p%0d_early", pass), 32'(b.trspvalid_o), 32'd0);
      if (pass == 1) begin
        clk_en_b = 1'b0;
        tick();
        checkOutput("t5_gap1", 32'(b.trspvalid_o), 32'd0);
        tick();
        checkOutput("t5_gap2", 32'(b.trspvalid_o), 32'd0);
        clk_en_b = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
        tick();
        checkOutput($sformatf("t5_p%0d_vld%0d", pass, k), 32'(b.trspvalid_o), 32'd1);
        checkOutput($sformatf("t5_p%0d_data%0d", pass, k), b.trspdata_o, exp_b[k]);
      end
      tick();
      checkOutput($sformatf("t5_p%0d_end", pass), 32'(b.trspvalid_o), 32'd0);
    end

    // Reset with responses in flight discards them but keeps memory
    a.trspready_i = 1'b0;
    applyStimulus(0, 0, 2'd2, 32'h00, 32'h0);
    applyStimulus(0, 0, 2'd2, 32'h04, 32'h0);
    applyStimulus(0, 0, 2'd2, 32'h08, 32'h0);
    checkOutput("t6_pre_vld", 32'(a.trspvalid_o), 32'd1);
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    checkOutput("t6_vld", 32'(a.trspvalid_o), 32'd0);
    checkOutput("t6_rdy", 32'(a.treqready_o), 32'd1);
    checkOutput("t6_data", a.trspdata_o, 32'd0);
    a.trspready_i = 1'b1;
    applyStimulus(0, 0, 2'd2, 32'h10, 32'h0);
    waitRsp(0, "t6_rd", 0, 0, 32'hBBBB3344, w);
    checkOutput("t6_rd_lat", 32'(w), 32'd1);
    checkOutput("t6_nostale", 32'(a.trspvalid_o), 32'd0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
